// File: rtl/c432_irq_capture.sv
// rtl/c432_irq_capture.sv - captures c432 decoder interrupt events into a small FIFO with drop accounting
module c432_irq_capture #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              pa,
    input  logic              pb,
    input  logic              pc,
    input  logic              irq,
    input  logic [2:0]        chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_chan,
    output logic [2:0]        out_bus,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              clr_ovf
);

    logic [5:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level_q;

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic accept;
    logic drop;

    assign push   = in_valid & irq;
    assign full   = (level_q == LW'(DEPTH));
    assign empty  = (level_q == '0);
    assign pop    = ~empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[wr_ptr] <= {pc, pb, pa, chan};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= DROP_W'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    assign out_valid           = ~empty;
    assign {out_bus, out_chan} = mem[rd_ptr];
    assign level               = level_q;

endmodule
